// File: rtl/delay_sensor_sampler.sv
// Samples the sensor's delayed clock through a 2-flop synchronizer, counts high
// samples over a 2^WIN_LOG2-cycle window and tracks running min/max of the count.
module delay_sensor_sampler #(
  parameter int WIN_LOG2 = 4,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_stats,
  input  logic             delayed_clk,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] cnt_min,
  output logic [CNT_W-1:0] cnt_max,
  output logic             stats_valid,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t               state, state_nxt;
  logic                 s1, s2;
  logic                 arm_cnt;
  logic [WIN_LOG2-1:0]  samp_cnt;
  logic [CNT_W-1:0]     hit_cnt;
  logic [CNT_W-1:0]     hit_sum;
  logic                 last_samp;

  function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign hit_sum   = hit_cnt + {{(CNT_W-1){1'b0}}, s2};
  assign last_samp = (state == RUN) && (samp_cnt == {WIN_LOG2{1'b1}});
  assign busy      = (state == ARM) || (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = ARM;
      ARM: begin
        if (!en)         state_nxt = IDLE;
        else if (arm_cnt) state_nxt = RUN;
      end
      RUN: begin
        // A window whose last sample is being taken always completes.
        if (last_samp)   state_nxt = en ? RUN : IDLE;
        else if (!en)    state_nxt = IDLE;
      end
      default:           state_nxt = IDLE;
    endcase
  end

  // Synchronizer stage: runs in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= delayed_clk;
      s2 <= s1;
    end
  end

  // Control and window counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      arm_cnt  <= 1'b0;
      samp_cnt <= '0;
      hit_cnt  <= '0;
      valid    <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid   <= last_samp;
      arm_cnt <= (state == ARM) ? ~arm_cnt : 1'b0;
      if ((state == RUN) && (state_nxt == RUN)) begin
        samp_cnt <= samp_cnt + 1'b1;
        hit_cnt  <= last_samp ? '0 : hit_sum;
      end else begin
        samp_cnt <= '0;
        hit_cnt  <= '0;
      end
    end
  end

  // Result and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      cnt_min     <= '0;
      cnt_max     <= '0;
      stats_valid <= 1'b0;
    end else if (last_samp) begin
      count       <= hit_sum;
      stats_valid <= 1'b1;
      // A coincident clear wipes history first, so the new count seeds min/max.
      if (clr_stats || !stats_valid) begin
        cnt_min <= hit_sum;
        cnt_max <= hit_sum;
      end else begin
        cnt_min <= umin(cnt_min, hit_sum);
        cnt_max <= umax(cnt_max, hit_sum);
      end
    end else if (clr_stats) begin
      cnt_min     <= '0;
      cnt_max     <= '0;
      stats_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_sensor_sampler.sv
// Directed bench for delay_sensor_sampler: table of single windows plus
// hand-written sequences for back-to-back, clear, abort and reset cases.
module tb_delay_sensor_sampler;

  localparam int WIN_LOG2 = 4;
  localparam int CNT_W    = WIN_LOG2 + 1;

  logic             clk = 1'b0;
  logic             rst, en, clr_stats, delayed_clk;
  logic [CNT_W-1:0] count, cnt_min, cnt_max;
  logic             stats_valid, valid, busy;

  delay_sensor_sampler #(.WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats),
    .delayed_clk(delayed_clk), .count(count), .cnt_min(cnt_min),
    .cnt_max(cnt_max), .stats_valid(stats_valid), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // pattern: 0 = held high, 1 = held low, 2 = toggle every clk starting high
  typedef struct {
    int pat;
    bit clr;
    int exp_count;
    int exp_min;
    int exp_max;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int pat   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pat == 2) delayed_clk = ~delayed_clk;
  endtask

  task automatic set_pat(input int p);
    pat = p;
    delayed_clk = (p == 1) ? 1'b0 : 1'b1;
  endtask

  task automatic run_until_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 40);
  endtask

  vec_t vecs[5];
  int   n;
  int   nv;

  initial begin
    vecs[0] = '{0, 1'b1, 16, 16, 16};
    vecs[1] = '{1, 1'b0,  0,  0, 16};
    vecs[2] = '{2, 1'b1,  8,  8,  8};
    vecs[3] = '{0, 1'b0, 16,  8, 16};
    vecs[4] = '{1, 1'b0,  0,  0, 16};

    rst = 1'b1; en = 1'b0; clr_stats = 1'b0; set_pat(1);
    repeat (3) tick();
    chk("reset_count", count, 0);
    chk("reset_min", cnt_min, 0);
    chk("reset_max", cnt_max, 0);
    chk("reset_stats_valid", stats_valid, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      set_pat(vecs[i].pat);
      repeat (3) tick();
      if (vecs[i].clr) begin
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk($sformatf("v%0d_clr_sv", i), stats_valid, 0);
        chk($sformatf("v%0d_clr_min", i), cnt_min, 0);
      end
      en = 1'b1;
      run_until_valid(n);
      chk($sformatf("v%0d_latency", i), n, 19);
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("v%0d_min", i), cnt_min, vecs[i].exp_min);
      chk($sformatf("v%0d_max", i), cnt_max, vecs[i].exp_max);
      chk($sformatf("v%0d_sv", i), stats_valid, 1);
      en = 1'b0;
      tick();
      chk($sformatf("v%0d_valid_pulse", i), valid, 0);
      repeat (2) tick();
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Back-to-back windows: next valid exactly 16 cycles later, none between
    set_pat(0);
    repeat (3) tick();
    en = 1'b1;
    run_until_valid(n);
    chk("b2b_first_latency", n, 19);
    nv = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (valid) nv++;
      if (k == 16) chk("b2b_valid_at_16", valid, 1);
    end
    chk("b2b_valid_count", nv, 1);
    chk("b2b_count", count, 16);
    chk("b2b_busy", busy, 1);
    en = 1'b0;
    repeat (3) tick();

    // Clear coincident with window completion: new count seeds min and max
    set_pat(1);
    repeat (3) tick();
    en = 1'b1;
    repeat (18) tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clrcoin_valid", valid, 1);
    chk("clrcoin_min", cnt_min, 0);
    chk("clrcoin_max", cnt_max, 0);
    chk("clrcoin_sv", stats_valid, 1);
    en = 1'b0;
    repeat (3) tick();

    // Abort at RUN sample 5
    set_pat(0);
    repeat (3) tick();
    en = 1'b1;
    repeat (8) tick();
    chk("abort_busy_before", busy, 1);
    en = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    nv = 0;
    repeat (20) begin
      if (valid) nv++;
      tick();
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_count_held", count, 0);
    en = 1'b1;
    run_until_valid(n);
    chk("reen_latency", n, 19);
    chk("reen_count", count, 16);
    chk("reen_min", cnt_min, 0);
    chk("reen_max", cnt_max, 16);
    en = 1'b0;
    repeat (3) tick();

    // en falls on the last-sample cycle: window still reports, then IDLE
    set_pat(1);
    repeat (3) tick();
    en = 1'b1;
    repeat (18) tick();
    en = 1'b0;
    tick();
    chk("lastfall_valid", valid, 1);
    chk("lastfall_count", count, 0);
    chk("lastfall_busy", busy, 0);
    repeat (3) tick();

    // Reset at RUN sample 10, en held high throughout
    set_pat(0);
    repeat (3) tick();
    en = 1'b1;
    repeat (13) tick();
    rst = 1'b1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_min", cnt_min, 0);
    chk("rst_max", cnt_max, 0);
    chk("rst_sv", stats_valid, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    run_until_valid(n);
    chk("rst_restart_latency", n, 19);
    chk("rst_restart_count", count, 16);
    chk("rst_restart_min", cnt_min, 16);
    chk("rst_restart_max", cnt_max, 16);
    en = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
